// File: rtl/control_card_pkg.sv
// Shared constants for the SUBLEQ control card: bus widths, ctrl bit map and
// the 4-bit state encodings that bench monitors also decode.
package control_card_pkg;
  localparam int DATAWIDTH = 8;
  localparam int CTRLWIDTH = 8;

  localparam int CTRL_ALU_LD0  = 0;
  localparam int CTRL_ALU_LD1  = 1;
  localparam int CTRL_ALU_MODE = 2;
  localparam int CTRL_ALU_READ = 3;
  localparam int CTRL_MEM_RD   = 4;
  localparam int CTRL_MEM_WR   = 5;
  localparam int CTRL_ALU_DONE = 6;
  localparam int CTRL_ALU_LEZ  = 7;

  typedef enum logic [3:0] {
    CTRL_ST_FETCH_A  = 4'd0,
    CTRL_ST_FETCH_B  = 4'd1,
    CTRL_ST_FETCH_C  = 4'd2,
    CTRL_ST_INC_LD   = 4'd3,
    CTRL_ST_INC_WAIT = 4'd4,
    CTRL_ST_INC_RD   = 4'd5,
    CTRL_ST_LD_A     = 4'd6,
    CTRL_ST_LD_B     = 4'd7,
    CTRL_ST_EX_WAIT  = 4'd8,
    CTRL_ST_WB       = 4'd9,
    CTRL_ST_BRANCH   = 4'd10,
    CTRL_ST_HALT     = 4'd11
  } state_t;

  function automatic logic is_lez(input logic [DATAWIDTH-1:0] v);
    return v[DATAWIDTH-1] | (v == '0);
  endfunction
endpackage

// File: rtl/control_card_if.sv
// Shared card bus: data (memory/ALU drive), addr (control card drives), ctrl
// (strobes from the control card, DONE/LEZ from the ALU).
interface control_card_if;
  import control_card_pkg::*;
  wire  [DATAWIDTH-1:0] data;
  logic [DATAWIDTH-1:0] addr;
  wire  [CTRLWIDTH-1:0] ctrl;

  modport master (input data, output addr, inout ctrl);
  modport slave  (output data, input addr, inout ctrl);
endinterface

// File: rtl/control_card.sv
// SUBLEQ sequencer: fetches a,b,c, uses the ALU card for PC+1 and mem[b]-mem[a],
// writes back to mem[b] and branches to c when the result is <= 0.
module control_card
  import control_card_pkg::*;
#(
  parameter logic [DATAWIDTH-1:0] RESET_PC     = '0,
  parameter int                   DONE_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  control_card_if.master       bus,
  output logic                 halt,
  output logic                 fault,
  output logic [DATAWIDTH-1:0] pc_dbg
);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  state_t               state, ret;
  logic [DATAWIDTH-1:0] pc, ra, rb, rc, addr_q;
  logic [TW-1:0]        tmo;
  logic                 lez, done, tmo_hit;
  logic [1:0]           alu_ld;
  logic                 alu_mode, rd_en, mem_rd;

  assign done    = bus.ctrl[CTRL_ALU_DONE];
  assign tmo_hit = (int'(tmo) + 1) >= DONE_TIMEOUT;
  assign pc_dbg  = pc;

  // Strobes are a pure decode of the registered state; only READ/WR see DONE.
  always_comb begin
    alu_ld   = 2'b00;
    alu_mode = 1'b0;
    rd_en    = 1'b0;
    mem_rd   = 1'b0;
    addr_q   = pc;
    unique case (state)
      CTRL_ST_FETCH_A, CTRL_ST_FETCH_B, CTRL_ST_FETCH_C: mem_rd = 1'b1;
      CTRL_ST_INC_LD: alu_ld = 2'b01;
      CTRL_ST_INC_RD: rd_en = 1'b1;
      CTRL_ST_LD_A: begin alu_mode = 1'b1; mem_rd = 1'b1; alu_ld = 2'b01; addr_q = ra; end
      CTRL_ST_LD_B: begin alu_mode = 1'b1; mem_rd = 1'b1; alu_ld = 2'b10; addr_q = rb; end
      CTRL_ST_EX_WAIT: alu_mode = 1'b1;
      CTRL_ST_WB: begin alu_mode = 1'b1; rd_en = 1'b1; addr_q = rb; end
      default: ;
    endcase
  end

  assign bus.addr                              = rst ? '0 : addr_q;
  assign bus.ctrl[CTRL_ALU_LD1:CTRL_ALU_LD0]   = rst ? 2'b00 : alu_ld;
  assign bus.ctrl[CTRL_ALU_MODE]               = ~rst & alu_mode;
  assign bus.ctrl[CTRL_ALU_READ]               = ~rst & rd_en & done;
  assign bus.ctrl[CTRL_MEM_RD]                 = ~rst & mem_rd;
  assign bus.ctrl[CTRL_MEM_WR]                 = ~rst & (state == CTRL_ST_WB) & done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CTRL_ST_FETCH_A;
      ret   <= CTRL_ST_FETCH_B;
      pc    <= RESET_PC;
      ra    <= '0;
      rb    <= '0;
      rc    <= '0;
      lez   <= 1'b0;
      halt  <= 1'b0;
      fault <= 1'b0;
      tmo   <= '0;
    end else begin
      unique case (state)
        CTRL_ST_FETCH_A: begin ra <= bus.data; ret <= CTRL_ST_FETCH_B; state <= CTRL_ST_INC_LD; end
        CTRL_ST_FETCH_B: begin rb <= bus.data; ret <= CTRL_ST_FETCH_C; state <= CTRL_ST_INC_LD; end
        CTRL_ST_FETCH_C: begin rc <= bus.data; ret <= CTRL_ST_LD_A;    state <= CTRL_ST_INC_LD; end
        CTRL_ST_INC_LD:  state <= CTRL_ST_INC_WAIT;
        CTRL_ST_INC_WAIT: begin tmo <= '0; state <= CTRL_ST_INC_RD; end
        CTRL_ST_INC_RD: begin
          if (done) begin
            pc    <= bus.data;
            state <= ret;
          end else if (tmo_hit) begin
            state <= CTRL_ST_HALT;
            halt  <= 1'b1;
            fault <= 1'b1;
          end else tmo <= tmo + 1'b1;
        end
        CTRL_ST_LD_A:    state <= CTRL_ST_LD_B;
        CTRL_ST_LD_B:    state <= CTRL_ST_EX_WAIT;
        CTRL_ST_EX_WAIT: begin tmo <= '0; state <= CTRL_ST_WB; end
        CTRL_ST_WB: begin
          if (done) begin
            lez   <= is_lez(bus.data);
            state <= CTRL_ST_BRANCH;
          end else if (tmo_hit) begin
            state <= CTRL_ST_HALT;
            halt  <= 1'b1;
            fault <= 1'b1;
          end else tmo <= tmo + 1'b1;
        end
        CTRL_ST_BRANCH: begin
          state <= CTRL_ST_FETCH_A;
          // c of all-ones on a taken branch is the halt instruction
          if (lez) begin
            if (&rc) begin
              state <= CTRL_ST_HALT;
              halt  <= 1'b1;
            end else pc <= rc;
          end
        end
        CTRL_ST_HALT: state <= CTRL_ST_HALT;
        default: begin state <= CTRL_ST_HALT; halt <= 1'b1; end
      endcase
    end
  end
endmodule

// File: tb/tb_control_card.sv
// Bench for control_card: memory + ALU card models, directed vectors, mid-run
// reset, DONE timeout, and random programs against a SUBLEQ interpreter.
module tb_control_card;
  import control_card_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       halt, fault;
  logic [7:0] pc_dbg;

  always #5 clk = ~clk;

  control_card_if cif ();

  control_card #(.RESET_PC(8'hFD), .DONE_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .bus(cif), .halt(halt), .fault(fault), .pc_dbg(pc_dbg)
  );

  wire [1:0] alu_ld   = cif.ctrl[CTRL_ALU_LD1:CTRL_ALU_LD0];
  wire       alu_mode = cif.ctrl[CTRL_ALU_MODE];
  wire       alu_read = cif.ctrl[CTRL_ALU_READ];
  wire       mem_rd   = cif.ctrl[CTRL_MEM_RD];
  wire       mem_wr   = cif.ctrl[CTRL_MEM_WR];
  wire [5:0] strobes  = cif.ctrl[CTRL_MEM_WR:CTRL_ALU_LD0];

  // memory card
  logic [7:0] mem [256];
  logic [7:0] mem_init [256];
  always @(posedge clk)
    if (load) mem <= mem_init;
    else if (mem_wr) mem[cif.addr] <= cif.data;

  // ALU card: lat_* = cycles until DONE returns; 0 = random 1..4; -1 = never
  logic       done = 1'b1;
  logic [7:0] alu_a, alu_res;
  int         lat_left = 0;
  int         lat_inc = 1, lat_ex = 1;

  function automatic int pick(input int m);
    return (m == 0) ? int'($urandom_range(4, 1)) : m;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      done     <= 1'b1;
      lat_left <= 0;
    end else if (alu_ld != 2'b00) begin
      if (!alu_mode) alu_res <= cif.addr + 8'd1;
      else if (alu_ld == 2'b01) alu_a <= cif.data;
      else alu_res <= cif.data - alu_a;
      done     <= 1'b0;
      lat_left <= pick(alu_mode ? lat_ex : lat_inc);
    end else if (!done && lat_left > 0) begin
      lat_left <= lat_left - 1;
      if (lat_left == 1) done <= 1'b1;
    end
  end

  assign cif.data = alu_read ? alu_res : (mem_rd ? mem[cif.addr] : 8'h00);
  assign cif.ctrl[CTRL_ALU_DONE] = done;
  assign cif.ctrl[CTRL_ALU_LEZ]  = 1'b0;

  // write monitor
  int         wr_cnt = 0;
  logic [7:0] wr_addr, wr_data;
  always @(posedge clk)
    if (mem_wr && !load) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= cif.addr;
      wr_data <= cif.data;
    end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    check("rst_strobes", strobes, 6'h00);
    check("rst_addr", cif.addr, 8'h00);
    check("rst_pc", pc_dbg, 8'hFD);
    check("rst_halt", {halt, fault}, 2'b00);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] c, va, vb, exp_m4, exp_pc;
    logic       exp_halt;
  } vec_t;

  // Wrap instruction at FD..FF (mem[81] -= mem[80], 10-3, no branch) then the vector at 0.
  task automatic load_prog(input vec_t v);
    for (int i = 0; i < 256; i++) mem_init[i] = 8'h00;
    mem_init[8'hFD] = 8'h80;
    mem_init[8'hFE] = 8'h81;
    mem_init[8'hFF] = 8'h00;
    mem_init[8'h80] = 8'd3;
    mem_init[8'h81] = 8'd10;
    mem_init[0] = 8'd3;
    mem_init[1] = 8'd4;
    mem_init[2] = v.c;
    mem_init[3] = v.va;
    mem_init[4] = v.vb;
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t       vt [6];
    logic [7:0] mm [256];
    logic [7:0] pc_m, a, b, c, r;
    logic       halt_m;
    int         snap, prev, guard;

    vt[0] = '{c:8'h06, va:8'h05, vb:8'h07, exp_m4:8'h02, exp_pc:8'h03, exp_halt:1'b0};
    vt[1] = '{c:8'h09, va:8'h07, vb:8'h07, exp_m4:8'h00, exp_pc:8'h09, exp_halt:1'b0};
    vt[2] = '{c:8'hFF, va:8'h08, vb:8'h02, exp_m4:8'hFA, exp_pc:8'h03, exp_halt:1'b1};
    vt[3] = '{c:8'h20, va:8'h01, vb:8'h80, exp_m4:8'h7F, exp_pc:8'h03, exp_halt:1'b0};
    vt[4] = '{c:8'h40, va:8'h00, vb:8'h80, exp_m4:8'h80, exp_pc:8'h40, exp_halt:1'b0};
    vt[5] = '{c:8'hFF, va:8'h05, vb:8'h06, exp_m4:8'h01, exp_pc:8'h03, exp_halt:1'b0};

    @(negedge clk);

    // directed vectors, fixed ALU latency -> 17 cycles per instruction
    for (int i = 0; i < 6; i++) begin
      load_prog(vt[i]);
      do_reset();
      step(12);
      check($sformatf("v%0d_wrap_pc", i), pc_dbg, 8'h00);
      step(5);
      check($sformatf("v%0d_wrap_mem", i), mem[8'h81], 8'h07);
      check($sformatf("v%0d_wrap_pc2", i), pc_dbg, 8'h00);
      step(17);
      check($sformatf("v%0d_pc", i), pc_dbg, vt[i].exp_pc);
      check($sformatf("v%0d_mem4", i), mem[4], vt[i].exp_m4);
      check($sformatf("v%0d_halt", i), halt, vt[i].exp_halt);
      check($sformatf("v%0d_fault", i), fault, 1'b0);
      if (vt[i].exp_halt) begin
        snap = wr_cnt;
        check("halt_strobes", strobes, 6'h00);
        check("halt_addr", cif.addr, vt[i].exp_pc);
        step(5);
        check("halt_no_wr", wr_cnt, snap);
        check("halt_pc_hold", pc_dbg, vt[i].exp_pc);
        check("halt_sticky", halt, 1'b1);
      end
    end

    // reset asserted while WB is writing: write must be suppressed
    load_prog(vt[0]);
    do_reset();
    step(32);
    check("midrst_wb_active", mem_wr, 1'b1);
    snap = wr_cnt;
    rst = 1'b1;
    #1;
    check("midrst_strobes0", strobes, 6'h00);
    check("midrst_addr0", cif.addr, 8'h00);
    step(1);
    check("midrst_pc", pc_dbg, 8'hFD);
    check("midrst_flags", {halt, fault}, 2'b00);
    step(1);
    check("midrst_strobes1", strobes, 6'h00);
    check("midrst_no_wr", wr_cnt, snap);
    check("midrst_mem4", mem[4], 8'h07);
    rst = 1'b0;
    step(17);
    check("midrst_restart_pc", pc_dbg, 8'h00);

    // DONE stuck low during writeback: WB entered at edge 15, 15 polls
    lat_ex = -1;
    load_prog(vt[0]);
    do_reset();
    snap = wr_cnt;
    step(29);
    check("tmo_before", {halt, fault}, 2'b00);
    step(1);
    check("tmo_fault", {halt, fault}, 2'b11);
    check("tmo_strobes", strobes, 6'h00);
    check("tmo_no_wr", wr_cnt, snap);
    check("tmo_mem", mem[8'h81], 8'd10);
    step(4);
    check("tmo_sticky", {halt, fault}, 2'b11);
    lat_ex = 1;

    // random programs with random ALU latency against a SUBLEQ interpreter
    lat_inc = 0;
    lat_ex  = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) mem_init[i] = 8'($urandom_range(255, 0));
      mm     = mem_init;
      pc_m   = 8'hFD;
      halt_m = 1'b0;
      do_reset();
      for (int n = 0; n < 30 && !halt_m; n++) begin
        a = mm[pc_m];
        b = mm[8'(pc_m + 8'd1)];
        c = mm[8'(pc_m + 8'd2)];
        pc_m = pc_m + 8'd3;
        r = mm[b] - mm[a];
        mm[b] = r;
        if ($signed(r) <= 8'sd0) begin
          if (c == 8'hFF) halt_m = 1'b1;
          else pc_m = c;
        end
        prev  = wr_cnt;
        guard = 0;
        while (wr_cnt == prev && guard < 300) begin
          @(negedge clk);
          guard++;
        end
        check("rnd_wb_seen", wr_cnt != prev, 1'b1);
        if (wr_cnt == prev) break;
        check("rnd_wr_addr", wr_addr, b);
        check("rnd_wr_data", wr_data, r);
        step(1);
        check("rnd_pc", pc_dbg, pc_m);
        check("rnd_halt", halt, halt_m);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
